pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Next-PC controller for the fetch unit: each cycle it decides the next PC and the PC write enable. Sources, in priority order: exception entry, eret return, hazard stall, taken branch/jump, sequential PC+4.
- Tracks exception-level (handler) state, delay-slot status and fetch-address faults.
- Runs a stall watchdog.
- Sits between the hazard unit, the D-stage branch comparator, CP0 and the fetch unit's nPC/WE inputs.

Parameters:
- RESET_PC, 32'h00003000, PC value after reset; also the low bound of the fetch range.
- TEXT_END, 32'h00004ffc, highest legal fetch address.
- HANDLER_PC, 32'h00004180, exception entry address.
- STALL_MAX, 255, stall cycles tolerated before deadlock is flagged; must fit in 8 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- pc  in  32  current PC from the fetch unit
- stall  in  1  hazard unit freeze of F/D
- br_taken  in  1  D-stage branch/jump redirect valid
- br_target  in  32  redirect target
- exc_req  in  1  CP0 exception/interrupt request (M stage)
- eret_req  in  1  eret committing
- epc  in  32  return address from CP0
- npc  out  32  next PC to the fetch unit
- pc_we  out  1  fetch-unit PC write enable
- flush  out  1  clear F/D and D/E pipeline registers this cycle
- in_delay_slot  out  1  instruction now at pc is a delay slot
- exl  out  1  sequencer is in handler state
- exc_masked  out  1  exc_req arrived while exl=1 and was dropped
- fetch_adel  out  1  pc is misaligned or outside [RESET_PC, TEXT_END]
- deadlock  out  1  sticky watchdog flag

Behaviour:
- States: RUN (exl=0) and HANDLER (exl=1). Registered: state, in_delay_slot, stall_cnt[7:0], deadlock.
- Reset (reset=0, asynchronous): state=RUN; in_delay_slot=0; stall_cnt=0; deadlock=0.
- During reset, combinational outputs hold: npc=RESET_PC, pc_we=1, flush=1.
- Per-cycle priority, combinational on inputs and state:
  1. exc_req and state=RUN: npc=HANDLER_PC, pc_we=1, flush=1. Next state HANDLER; in_delay_slot<=0.
  2. eret_req, in either state: npc=epc, pc_we=1, flush=1. Next state RUN; in_delay_slot<=0.
  3. stall: pc_we=0; npc=pc+4 (don't-care); in_delay_slot holds.
  4. br_taken: npc=br_target, pc_we=1, in_delay_slot<=1.
  5. Otherwise: npc=pc+4, pc_we=1, in_delay_slot<=0.
- exc_req while in HANDLER:
  - Ignored for redirect purposes; evaluation continues at rule 2.
  - exc_masked=1 for that cycle only (combinational).
- exc_req and eret_req together in RUN: exception wins; eret is lost (it has been flushed).
- exc_req and eret_req together in HANDLER: eret wins; exc_masked=1.
- Exception or eret overrides stall and br_taken in the same cycle. A pending delay slot is discarded.
- npc arithmetic is 32-bit, wraps modulo 2^32, with no alignment correction. A bad target reaches pc and is reported through fetch_adel.
- fetch_adel is combinational: set when pc[1:0]!=0, pc<RESET_PC or pc>TEXT_END.
- Watchdog:
  - stall_cnt increments on cycles where stall=1 and no rule 1/2 fires; it saturates at 255.
  - Cleared to 0 on any cycle where stall=0 or a redirect by rule 1/2 occurs.
  - deadlock<=1 when stall_cnt==STALL_MAX and stall=1; it stays set until reset.
- Latency: npc and pc_we are 0-cycle combinational. State and delay-slot updates take effect at the next posedge.

Decomposition:
- Shared CPU package: RESET_PC, TEXT_END, HANDLER_PC and the state encodings RUN=1'b0, HANDLER=1'b1. CP0 and the fetch unit use the same constants.
- One natural sub-module, pc_stall_watchdog: the counter plus sticky flag. Its inputs are clk, reset, stall and clr; its output is deadlock.

Test Plan:
- Reset then release with pc=32'h3000 and no inputs: npc=32'h3004, pc_we=1, flush=0, exl=0, fetch_adel=0.
- br_taken=1, br_target=32'h3100 at pc=32'h3008: npc=32'h3100. On the next cycle in_delay_slot=1; on the following cycle it is 0.
- exc_req during stall=1 and br_taken=1: npc=32'h4180, pc_we=1, flush=1, then exl=1. A second exc_req gives exc_masked=1 with no redirect. Then eret_req with epc=32'h3020: npc=32'h3020, flush=1, exl=0.
- pc=32'h3002, then pc=32'h5000, then pc=32'h2ffc: fetch_adel=1 for each. pc=32'h4ffc: fetch_adel=0.
- stall held for 256 cycles: deadlock rises on the cycle after stall_cnt reaches 255. Dropping stall leaves deadlock=1; reset clears it.
- reset pulled low asynchronously mid-cycle while in HANDLER with in_delay_slot=1: exl=0 and in_delay_slot=0 immediately; npc=32'h3000 while reset is held.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU constants for the fetch path: reset/handler vectors, text bounds
// and the sequencer state encoding used by CP0 and the fetch unit.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] TEXT_END   = 32'h0000_4ffc;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [7:0]  STALL_MAX  = 8'd255;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } seq_state_e;

endpackage

// File: rtl/pc_stall_watchdog.sv
// Stall watchdog: counts consecutive un-redirected stall cycles and raises a
// sticky deadlock flag once the run reaches STALL_MAX.
module pc_stall_watchdog #(
    parameter logic [7:0] STALL_MAX = 8'd255
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic clr,
    output logic deadlock
);

    logic [7:0] stall_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 8'd0;
            deadlock  <= 1'b0;
        end else begin
            if (clr) begin
                stall_cnt <= 8'd0;
            end else if (stall_cnt != 8'hff) begin
                stall_cnt <= stall_cnt + 8'd1;
            end
            if (stall && (stall_cnt == STALL_MAX)) begin
                deadlock <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks the fetch unit's next PC from exception entry,
// eret return, stall, taken branch or PC+4, and tracks handler/delay-slot state.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] P_RESET_PC   = RESET_PC,
    parameter logic [31:0] P_TEXT_END   = TEXT_END,
    parameter logic [31:0] P_HANDLER_PC = HANDLER_PC,
    parameter logic [7:0]  P_STALL_MAX  = STALL_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] npc,
    output logic        pc_we,
    output logic        flush,
    output logic        in_delay_slot,
    output logic        exl,
    output logic        exc_masked,
    output logic        fetch_adel,
    output logic        deadlock
);

    seq_state_e state, next_state;
    logic       next_ds;
    logic       redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= RUN;
            in_delay_slot <= 1'b0;
        end else begin
            state         <= next_state;
            in_delay_slot <= next_ds;
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        npc        = pc + 32'd4;
        pc_we      = 1'b1;
        flush      = 1'b0;
        next_state = state;
        next_ds    = 1'b0;
        redirect   = 1'b0;
        exc_masked = 1'b0;

        if (!reset) begin
            npc   = P_RESET_PC;
            flush = 1'b1;
        end else begin
            // In the handler a new exception is dropped and flagged, not taken.
            exc_masked = exc_req && (state == HANDLER);
            if (exc_req && (state == RUN)) begin
                npc        = P_HANDLER_PC;
                flush      = 1'b1;
                next_state = HANDLER;
                redirect   = 1'b1;
            end else if (eret_req) begin
                npc        = epc;
                flush      = 1'b1;
                next_state = RUN;
                redirect   = 1'b1;
            end else if (stall) begin
                pc_we   = 1'b0;
                next_ds = in_delay_slot;
            end else if (br_taken) begin
                npc     = br_target;
                next_ds = 1'b1;
            end
        end
    end

    assign exl        = (state == HANDLER);
    assign fetch_adel = (pc[1:0] != 2'b00) || (pc < P_RESET_PC) || (pc > P_TEXT_END);

    pc_stall_watchdog #(
        .STALL_MAX (P_STALL_MAX)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .clr      (!stall || redirect),
        .deadlock (deadlock)
    );

endmodule
